// File: rtl/eprom_prog.sv
// eprom_prog: behavioural EPROM with OR-only word programming, sector/chip erase,
// single-cycle registered reads and a busy/done handshake for long operations.
module eprom_prog #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 4,
    parameter int SECT_W       = 2,
    parameter int PROG_CYCLES  = 4,
    parameter int ERASE_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wp,
    output logic              cmd_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int MAXC  = PROG_CYCLES > ERASE_CYCLES ? PROG_CYCLES : ERASE_CYCLES;
    localparam int CW    = $clog2(MAXC + 1);
    typedef enum logic [1:0] {IDLE, PROG, ERASE, DONE} state_t;
    typedef logic [DEPTH-1:0][DATA_W-1:0] mem_t;
    function automatic mem_t init_mem();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) m[i] = DATA_W'(i + 1);
        return m;
    endfunction
    // Array contents survive reset; only the power-up image is defined.
    mem_t mem_q = init_mem();
    mem_t mem_d;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic chip_q, chip_d, err_q, err_d, rd_valid_q, rd_valid_d;
    logic fire;
    assign fire = cnt_q == '0;
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        chip_d     = chip_q;
        err_d      = 1'b0;
        rdata_d    = rdata_q;
        rd_valid_d = 1'b0;
        case (state_q)
            IDLE: if (cmd_valid) begin
                if (cmd == 2'b00) begin
                    rdata_d    = mem_q[addr];
                    rd_valid_d = 1'b1;
                end else if (wp) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    chip_d  = cmd[0];
                    state_d = cmd == 2'b01 ? PROG : ERASE;
                    cnt_d   = cmd == 2'b01 ? CW'(PROG_CYCLES - 1) : CW'(ERASE_CYCLES - 1);
                end
            end
            PROG, ERASE: if (fire) begin
                state_d = DONE;
                err_d   = state_q == PROG && ((mem_q[addr_q] | wdata_q) != wdata_q);
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        mem_d = mem_q;
        if (state_q == PROG && fire) mem_d[addr_q] = mem_q[addr_q] | wdata_q;
        for (int i = 0; i < DEPTH; i++)
            if (state_q == ERASE && fire && (chip_q || (ADDR_W'(i) >> SECT_W) == (addr_q >> SECT_W)))
                mem_d[i] = '0;
    end
    always_ff @(posedge clk)
        if (!rst) mem_q <= mem_d;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            chip_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            chip_q     <= chip_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            rd_valid_q <= rd_valid_d;
        end
    end
    assign cmd_ready = state_q == IDLE;
    assign busy      = state_q == PROG || state_q == ERASE;
    assign done      = state_q == DONE;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign rd_valid  = rd_valid_q;
endmodule

// File: tb/tb_eprom_prog.sv
// tb_eprom_prog: directed checks of reads, program, erase, write protect and reset abort.
module tb_eprom_prog;
    logic        clk = 1'b0, rst = 1'b0, cmd_valid = 1'b0, wp = 1'b0;
    logic [1:0]  cmd = 2'b00;
    logic [3:0]  addr = '0;
    logic [15:0] wdata = '0;
    logic        cmd_ready, rd_valid, busy, done, err;
    logic [15:0] rdata;
    int checks = 0, errors = 0;

    eprom_prog dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .addr(addr),
        .wdata(wdata), .wp(wp), .cmd_ready(cmd_ready), .rdata(rdata),
        .rd_valid(rd_valid), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [3:0] a, input logic [15:0] exp);
        cmd_valid = 1'b1; cmd = 2'b00; addr = a;
        tick();
        cmd_valid = 1'b0;
        chk($sformatf("rd_valid@%0d", a), {31'd0, rd_valid}, 32'd1);
        chk($sformatf("rdata@%0d", a), {16'd0, rdata}, {16'd0, exp});
    endtask

    // Launch an operation, scramble inputs and hold a bogus chip erase request while busy.
    task automatic run_op(input logic [1:0] c, input logic [3:0] a, input logic [15:0] d,
                          input logic w, input int exp_busy, input logic exp_err, input string tag);
        int n;
        cmd_valid = 1'b1; cmd = c; addr = a; wdata = d; wp = w;
        tick();
        cmd = 2'b11; addr = ~a; wdata = 16'hFFFF; wp = 1'b0;
        n = 0;
        while (busy && n < 50) begin
            n++;
            tick();
        end
        cmd_valid = 1'b0; wp = 1'b0;
        chk({tag, "_busy_cycles"}, n, exp_busy);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        tick();
        chk({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
        chk({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_rdata", {16'd0, rdata}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        for (int a = 0; a < 16; a++) rd(4'(a), 16'(a + 1));
        tick();
        chk("rd_valid_idle", {31'd0, rd_valid}, 32'd0);
        chk("rdata_hold", {16'd0, rdata}, 32'h10);

        run_op(2'b11, 4'd0, 16'd0, 1'b1, 0, 1'b1, "wp_chip");
        for (int a = 0; a < 16; a += 5) rd(4'(a), 16'(a + 1));

        cmd_valid = 1'b1; cmd = 2'b01; addr = 4'd2; wdata = 16'hFFFF; wp = 1'b0;
        tick();
        cmd_valid = 1'b0;
        chk("abort_busy1", {31'd0, busy}, 32'd1);
        tick();
        chk("abort_busy2", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy_low", {31'd0, busy}, 32'd0);
        chk("abort_done_low", {31'd0, done}, 32'd0);
        chk("abort_err_low", {31'd0, err}, 32'd0);
        chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        tick();
        tick();
        rst = 1'b0;
        chk("abort_no_done", {31'd0, done}, 32'd0);
        rd(4'd2, 16'h0003);

        run_op(2'b10, 4'd6, 16'd0, 1'b0, 8, 1'b0, "sect");
        rd(4'd3, 16'h0004);
        for (int a = 4; a < 8; a++) rd(4'(a), 16'h0000);
        rd(4'd8, 16'h0009);
        rd(4'd15, 16'h0010);

        run_op(2'b11, 4'd0, 16'd0, 1'b0, 8, 1'b0, "chip");
        rd(4'd0, 16'h0000);
        rd(4'd12, 16'h0000);
        run_op(2'b01, 4'd5, 16'h00F0, 1'b0, 4, 1'b0, "prog");
        rd(4'd5, 16'h00F0);
        rd(4'd4, 16'h0000);
        run_op(2'b01, 4'd5, 16'h000F, 1'b0, 4, 1'b1, "prog_bitclr");
        rd(4'd5, 16'h00FF);
        run_op(2'b01, 4'd15, 16'h8001, 1'b0, 4, 1'b0, "prog_top");
        rd(4'd15, 16'h8001);
        run_op(2'b01, 4'd15, 16'h0001, 1'b1, 0, 1'b1, "wp_prog");
        rd(4'd15, 16'h8001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/eprom_prog.md
EPROM_PROG -- requirements
Module: eprom_prog

Interface
REQ-001 Parameter DATA_W, default 16, word width in bits.
REQ-002 Parameter ADDR_W, default 4, address width; depth = 2**ADDR_W words.
REQ-003 Parameter SECT_W, default 2, log2 of words per sector; SECT_W <= ADDR_W.
REQ-004 Parameter PROG_CYCLES, default 4, busy cycles per program (>=1).
REQ-005 Parameter ERASE_CYCLES, default 8, busy cycles per sector or chip erase (>=1).
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 cmd_valid  input  1  command request.
REQ-009 cmd  input  2  00 read, 01 program, 10 sector erase, 11 chip erase.
REQ-010 addr  input  ADDR_W  word address; upper ADDR_W-SECT_W bits select the sector for sector erase.
REQ-011 wdata  input  DATA_W  program data.
REQ-012 wp  input  1  write protect; sampled at command acceptance.
REQ-013 cmd_ready  output  1  command can be accepted this cycle.
REQ-014 rdata  output  DATA_W  registered read data.
REQ-015 rd_valid  output  1  one-cycle pulse, rdata valid.
REQ-016 busy  output  1  program/erase in progress.
REQ-017 done  output  1  one-cycle completion pulse for program/erase.
REQ-018 err  output  1  status qualifier, valid only while done=1.

Function
REQ-019 Command accepted on a rising edge where cmd_valid=1 and cmd_ready=1; otherwise cmd_valid is ignored, with no queueing.
REQ-020 FSM states: IDLE, PROG, ERASE, DONE; cmd_ready=1 only in IDLE; busy=1 in PROG and ERASE; done=1 only in DONE.
REQ-021 Read accepted in IDLE: rdata=array[addr] and rd_valid=1 in the cycle after acceptance; FSM stays IDLE, so back-to-back reads give one word per cycle.
REQ-022 rd_valid is 0 in any cycle not directly following an accepted read; rdata holds its last value.
REQ-023 Program/erase accepted with wp=1: go to DONE next cycle with err=1; array unchanged.
REQ-024 Program accepted with wp=0: latch addr and wdata, go to PROG, load counter with PROG_CYCLES-1.
REQ-025 In PROG/ERASE, counter decrements each edge; on the edge where counter=0, apply the operation and go to DONE.
REQ-026 Program semantics: array[a] <= array[a] | wdata (bits can only be set, never cleared).
REQ-027 Program err=1 if (old | wdata) != wdata, i.e. a requested 0 bit was already 1; the OR result is still written.
REQ-028 Sector erase: all 2**SECT_W words of the latched sector <= 0 at once; err=0.
REQ-029 Chip erase: all words <= 0 at once; err=0.
REQ-030 Erase length uses ERASE_CYCLES; the counter is wide enough for max(PROG_CYCLES, ERASE_CYCLES)-1.
REQ-031 DONE lasts exactly one cycle, then IDLE. Program timing: acceptance edge E; array updated at edge E+PROG_CYCLES; done high in the following cycle; cmd_ready=1 after edge E+PROG_CYCLES+1.
REQ-032 Changes to addr, wdata, wp or cmd after acceptance have no effect on the operation in progress.
REQ-033 At time zero, array word i holds i+1 (0x0001 ... 0x0010 at default parameters).

Reset
REQ-034 rst=1: FSM -> IDLE, counter=0, rdata=0, rd_valid=0, busy=0, done=0, err=0, cmd_ready=1; outputs change immediately on assertion.
REQ-035 Reset does not modify array contents.
REQ-036 Reset during PROG or ERASE aborts the operation: no array word is modified and no done pulse is produced.
REQ-037 Commands are accepted on the first rising edge after rst deasserts.

Verification
REQ-038 Read sweep: reads addr 0..15 back-to-back -> rd_valid every cycle, rdata 0x0001..0x0010.
REQ-039 Program: chip erase, then program addr 5 with 0x00F0 -> busy 4 cycles, done with err=0; read addr 5 = 0x00F0.
REQ-040 Bit-clear error: program addr 5 with 0x000F over 0x00F0 -> done with err=1; read = 0x00FF.
REQ-041 Sector erase at addr 6 (sector 1) -> busy 8 cycles; addr 4..7 read 0; addr 3 and addr 8 unchanged (0x0004, 0x0009).
REQ-042 wp=1 chip erase -> done with err=1 in the cycle after acceptance; all words unchanged.
REQ-043 rst asserted in the 2nd busy cycle of program to addr 2 -> busy, done and err low immediately; addr 2 still 0x0003; next command accepted.
